// File: rtl/i2s2_axil_pkg.sv
// Shared definitions for the I2S2 AXI4-Lite register path: FSM states,
// response codes and the slave register map.
package i2s2_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_DONE    = 3'd5
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;

endpackage

// File: rtl/i2s2_axil_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester was not served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = requester 1 served last; reset value lets requester 0 win the first tie
  logic r_last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_last <= 1'b1;
    else if (advance && |req) r_last <= grant[1];
  end

endmodule

// File: rtl/i2s2_axil_arbiter.sv
// Serialises register accesses from two requesters onto one AXI4-Lite master
// port, one outstanding transaction at a time.
module i2s2_axil_arbiter
  import i2s2_axil_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_done,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  axil_state_e         r_state;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

  logic [1:0]          w_grant;
  logic                w_take, w_g1, w_we, w_aw_ok, w_w_ok;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_take  = (r_state == ST_IDLE) && (|req_valid);
  assign w_g1    = w_grant[1];
  assign w_we    = w_g1 ? req_we[1] : req_we[0];
  // Word-aligned: the slave only decodes whole 32-bit registers
  assign w_addr  = {(w_g1 ? req_addr[2*ADDR_W-1:ADDR_W+2] : req_addr[ADDR_W-1:2]), 2'b00};
  assign w_wdata = w_g1 ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // A channel is finished once its valid has already dropped or is handshaking now
  assign w_aw_ok = !r_awvalid || m_axi_awready;
  assign w_w_ok  = !r_wvalid  || m_axi_wready;

  rr_arb2 u_rr (
    .clk     (ACLK),
    .rst     (ARESET),
    .req     (req_valid),
    .advance (w_take),
    .grant   (w_grant)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_take) begin
          r_gnt <= w_grant;
          if (w_we) begin
            r_state   <= ST_WR_AW_W;
            r_awaddr  <= w_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= '1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end else begin
            r_state   <= ST_RD_AR;
            r_araddr  <= w_addr;
            r_arvalid <= 1'b1;
          end
        end
        ST_WR_AW_W: begin
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_state   <= ST_WR_B;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bready  <= 1'b1;
          end
        end
        ST_WR_B: if (m_axi_bvalid) begin
          r_state  <= ST_DONE;
          r_bready <= 1'b0;
          r_resp   <= m_axi_bresp;
          r_rdata  <= '0;
          r_done   <= r_gnt;
        end
        ST_RD_AR: if (m_axi_arready) begin
          r_state   <= ST_RD_R;
          r_arvalid <= 1'b0;
          r_araddr  <= '0;
          r_rready  <= 1'b1;
        end
        ST_RD_R: if (m_axi_rvalid) begin
          r_state  <= ST_DONE;
          r_rready <= 1'b0;
          r_resp   <= m_axi_rresp;
          r_rdata  <= m_axi_rdata;
          r_done   <= r_gnt;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_done      = r_done;
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;
  assign busy          = (r_state != ST_IDLE);
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_i2s2_axil_arbiter.sv
// Bench for i2s2_axil_arbiter: two requester drivers, a 4-register AXI-Lite
// slave with programmable stalls, and a transaction-level expectation queue.
module tb_i2s2_axil_arbiter;
  import i2s2_axil_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [1:0]      req_valid, req_we, req_done, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]      m_axi_awprot, m_axi_arprot;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic            m_axi_rvalid, m_axi_rready;

  always #5 ACLK = ~ACLK;

  i2s2_axil_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++; bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------- expectation model ----------------
  typedef struct {
    int          g;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          t0;
  } txn_t;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          gap;
  } rq_t;

  txn_t        exp_q[$];
  logic [31:0] mmem [4];
  int          last_g;
  int          cyc = 0;
  int          dlog_g[$];
  logic [31:0] dlog_rd[$];
  logic [1:0]  dlog_rs[$];
  int          last_lat;

  // ---------------- requester drivers ----------------
  rq_t plan [2][$];
  rq_t cur  [2];
  bit  active [2];
  bit  granted [2];

  // ---------------- slave ----------------
  logic [31:0] smem [4];
  int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int  aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit  aw_got, w_got, b_pend, r_pend, saw_split;
  int  nb_b;
  logic [3:0]  s_awaddr, last_awaddr;
  logic [31:0] s_wdata, last_wdata, s_rdata;
  logic [3:0]  s_wstrb, last_wstrb;
  logic [1:0]  s_rresp;
  logic        p_awv, p_wv, p_bready, p_arv, p_rready;
  logic [3:0]  p_awaddr, p_araddr, p_wstrb;
  logic [31:0] p_wdata;

  function automatic bit zero_wait();
    return (aw_dly + w_dly + b_dly + ar_dly + r_dly) == 0;
  endfunction

  task automatic env_reset();
    exp_q.delete();
    plan[0].delete(); plan[1].delete();
    for (int i = 0; i < 2; i++) begin active[i] = 0; granted[i] = 0; end
    last_g = 1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
    p_awaddr = '0; p_araddr = '0; p_wstrb = '0; p_wdata = '0;
  endtask

  // Runs once per negative edge: settle handshakes of the previous rising
  // edge, check outputs, then drive requesters and slave for the next edge.
  task automatic tick();
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    txn_t e;
    int g;
    cyc++;
    if (ARESET) begin env_reset(); return; end

    hs_aw = p_awv && m_axi_awready;
    hs_w  = p_wv && m_axi_wready;
    hs_b  = m_axi_bvalid && p_bready;
    hs_ar = p_arv && m_axi_arready;
    hs_r  = m_axi_rvalid && p_rready;
    if (p_awv && !hs_aw) chk("awvalid_hold", m_axi_awvalid, 1);
    if (p_wv && !hs_w)   chk("wvalid_hold", m_axi_wvalid, 1);
    if (p_arv && !hs_ar) chk("arvalid_hold", m_axi_arvalid, 1);

    if (hs_aw) begin aw_got = 1; s_awaddr = p_awaddr; end
    if (hs_w)  begin w_got = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
    if (aw_got) chk("awvalid_after_hs", m_axi_awvalid, 0);
    if (w_got)  chk("wvalid_after_hs", m_axi_wvalid, 0);
    if (aw_got && w_got) begin
      last_awaddr = s_awaddr; last_wdata = s_wdata; last_wstrb = s_wstrb;
      smem[s_awaddr[3:2]] = s_wdata;
      if (exp_q.size() == 0) fail_now("unexpected_write");
      else begin
        chk("is_write", 1, exp_q[0].we);
        chk("aw_addr", s_awaddr, exp_q[0].addr);
        chk("w_data", s_wdata, exp_q[0].wdata);
        chk("w_strb", s_wstrb, 4'hF);
      end
      aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
    end
    if (hs_b) begin b_pend = 0; nb_b++; end
    if (hs_ar) begin
      if (p_araddr == REG3) begin s_rdata = 32'hDEADBEEF; s_rresp = RESP_SLVERR; end
      else begin s_rdata = smem[p_araddr[3:2]]; s_rresp = RESP_OKAY; end
      if (exp_q.size() == 0) fail_now("unexpected_read");
      else begin
        chk("is_read", 0, exp_q[0].we);
        chk("ar_addr", p_araddr, exp_q[0].addr);
      end
      r_pend = 1; r_wait = 0;
    end
    if (hs_r) r_pend = 0;

    chk("busy", busy, exp_q.size() != 0);
    if (m_axi_awvalid) chk("awprot", m_axi_awprot, 0);
    if (m_axi_arvalid) chk("arprot", m_axi_arprot, 0);
    if (m_axi_wvalid)  chk("wstrb", m_axi_wstrb, 4'hF);
    if (!m_axi_awvalid && !m_axi_wvalid) chk("aw_w_idle", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
    if (!m_axi_arvalid) chk("ar_idle", m_axi_araddr, 0);
    if (!busy) chk("idle_outs", {m_axi_bready, m_axi_rready, req_done}, 0);
    if (!m_axi_awvalid && m_axi_wvalid) saw_split = 1;

    if (req_done != 2'b00) begin
      if (exp_q.size() == 0) fail_now("unexpected_done");
      else begin
        e = exp_q.pop_front();
        chk("done_onehot", req_done, 2'b01 << e.g);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        if (e.we) chk("b_count", nb_b, 1);
        last_lat = cyc - e.t0;
        if (zero_wait()) chk("latency", last_lat, 3);
        dlog_g.push_back(e.g); dlog_rd.push_back(rsp_rdata); dlog_rs.push_back(rsp_resp);
        active[e.g] = 0; granted[e.g] = 0;
      end
    end else if (exp_q.size() != 0 && cyc - exp_q[0].t0 > 400) begin
      fail_now("txn_timeout");
      e = exp_q.pop_front();
      active[e.g] = 0; granted[e.g] = 0;
    end

    for (int i = 0; i < 2; i++) begin
      if (!active[i] && plan[i].size() != 0) begin
        if (plan[i][0].gap > 0) plan[i][0].gap--;
        else begin cur[i] = plan[i].pop_front(); active[i] = 1; end
      end
      req_valid[i] = active[i];
      if (active[i] && !granted[i]) begin
        req_we[i] = cur[i].we;
        req_addr[i*AW +: AW] = cur[i].addr;
        req_wdata[i*DW +: DW] = cur[i].wdata;
      end else begin
        req_we[i] = 1'($urandom);
        req_addr[i*AW +: AW] = 4'($urandom);
        req_wdata[i*DW +: DW] = $urandom;
      end
    end

    if (!busy && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? 1 - last_g : (req_valid[1] ? 1 : 0);
      e.g = g; e.we = req_we[g]; e.t0 = cyc;
      e.addr = {req_addr[g*AW+2 +: 2], 2'b00};
      e.wdata = req_wdata[g*DW +: DW];
      if (e.we) begin mmem[e.addr[3:2]] = e.wdata; e.rdata = 0; e.resp = RESP_OKAY; end
      else if (e.addr == REG3) begin e.rdata = 32'hDEADBEEF; e.resp = RESP_SLVERR; end
      else begin e.rdata = mmem[e.addr[3:2]]; e.resp = RESP_OKAY; end
      exp_q.push_back(e);
      granted[g] = 1; last_g = g; nb_b = 0;
    end

    m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
    aw_wait = m_axi_awvalid ? aw_wait + 1 : 0;
    m_axi_wready = m_axi_wvalid && (w_wait >= w_dly);
    w_wait = m_axi_wvalid ? w_wait + 1 : 0;
    m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
    ar_wait = m_axi_arvalid ? ar_wait + 1 : 0;
    m_axi_bvalid = b_pend && (b_wait >= b_dly);
    m_axi_bresp = RESP_OKAY;
    if (b_pend) b_wait++;
    m_axi_rvalid = r_pend && (r_wait >= r_dly);
    m_axi_rdata = s_rdata; m_axi_rresp = s_rresp;
    if (r_pend) r_wait++;

    p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_bready = m_axi_bready;
    p_arv = m_axi_arvalid; p_rready = m_axi_rready;
    p_awaddr = m_axi_awaddr; p_araddr = m_axi_araddr;
    p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin @(negedge ACLK); tick(); end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (plan[0].size() == 0 && plan[1].size() == 0 && !active[0] && !active[1] &&
          exp_q.size() == 0 && !busy) return;
    end
    fail_now("wait_idle_timeout");
  endtask

  task automatic add(input int i, input bit we, input logic [3:0] a, input logic [31:0] d, input int gap);
    rq_t r;
    r.we = we; r.addr = a; r.wdata = d; r.gap = gap;
    plan[i].push_back(r);
  endtask

  function automatic int lg(input int k);
    return (k < dlog_g.size()) ? dlog_g[k] : -1;
  endfunction

  task automatic clear_log();
    dlog_g.delete(); dlog_rd.delete(); dlog_rs.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mmem[i] = '0; smem[i] = '0; end
    s_rdata = '0; s_rresp = '0; last_lat = 0; saw_split = 0; nb_b = 0;
    ARESET = 1'b1;
    env_reset();
    step(3);
    #1;
    chk("rst_axi_outs", {m_axi_awaddr, m_axi_awprot, m_axi_awvalid, m_axi_wvalid, m_axi_wstrb,
                         m_axi_bready, m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_rsp", {req_done, rsp_resp, rsp_rdata}, 0);
    chk("rst_busy", busy, 0);
    ARESET = 1'b0;
    step(2);

    // simultaneous write by req0 and read by req1 of the same register
    clear_log();
    add(0, 1, 4'h0, 32'h1, 0);
    add(1, 0, 4'h0, 32'h0, 0);
    wait_idle(100);
    chk("t034_first", lg(0), 0);
    chk("t034_second", lg(1), 1);
    chk("t034_rdata", (dlog_rd.size() > 1) ? dlog_rd[1] : 32'hX, 32'h1);

    // single zero-wait write
    clear_log();
    add(0, 1, 4'h4, 32'h2, 0);
    wait_idle(100);
    chk("t033_awaddr", last_awaddr, 4'h4);
    chk("t033_wdata", last_wdata, 32'h2);
    chk("t033_wstrb", last_wstrb, 4'hF);
    chk("t033_done_cycle", last_lat + 1, 4);
    chk("t033_who", lg(0), 0);
    chk("t033_resp", (dlog_rs.size() > 0) ? dlog_rs[0] : 2'bxx, 2'b00);

    // read of the error register
    clear_log();
    add(1, 0, 4'hC, 32'h0, 0);
    wait_idle(100);
    chk("t037_resp", (dlog_rs.size() > 0) ? dlog_rs[0] : 2'bxx, 2'b10);
    chk("t037_rdata", (dlog_rd.size() > 0) ? dlog_rd[0] : 32'hX, 32'hDEADBEEF);

    // both requesters held valid back to back
    clear_log();
    add(0, 1, 4'h8, 32'h11, 0); add(0, 0, 4'h4, 32'h0, 0);
    add(1, 0, 4'h8, 32'h0, 0);  add(1, 1, 4'h0, 32'h22, 0);
    wait_idle(200);
    chk("t035_g0", lg(0), 0);
    chk("t035_g1", lg(1), 1);
    chk("t035_g2", lg(2), 0);
    chk("t035_g3", lg(3), 1);

    // AW accepted three cycles ahead of W
    aw_dly = 0; w_dly = 3; saw_split = 0;
    add(0, 1, 4'h8, 32'hA5A5_5A5A, 0);
    wait_idle(100);
    chk("t036_split_seen", saw_split, 1);
    chk("t036_b_count", nb_b, 1);
    chk("t036_wdata", last_wdata, 32'hA5A5_5A5A);
    w_dly = 0;

    // reset while waiting for B, then a tie after release
    b_dly = 20;
    add(0, 1, 4'h4, 32'h55, 0);
    begin
      bit seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin step(1); seen = m_axi_bready; end
      if (!seen) fail_now("t038_no_wr_b");
    end
    #2 ARESET = 1'b1;
    #1;
    chk("t038_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
    chk("t038_done", req_done, 0);
    chk("t038_busy", busy, 0);
    step(2);
    ARESET = 1'b0;
    b_dly = 0;
    clear_log();
    add(0, 0, 4'h4, 32'h0, 1);
    add(1, 0, 4'h8, 32'h0, 1);
    wait_idle(100);
    chk("t038_tie_first", lg(0), 0);
    chk("t038_tie_second", lg(1), 1);

    // randomized traffic with random slave stalls
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; end
      else begin
        aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
        ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      end
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 10; k++)
          add(i, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3));
      wait_idle(3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
